alu_issue_stage: RTL

//  Execute-stage sequencer directly upstream of the ALU: accepts decoded micro-ops over valid/ready,

---
 rtl/alu_issue_if.sv | 34 +++
 rtl/alu_issue_stage.sv | 108 ++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: decoded-op handshake, ALU drive/return, commit and debug signals of the issue stage.
interface alu_issue_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_uop;
    logic [3:0]      in_rd;
    logic [3:0]      in_rn;
    logic [3:0]      in_rm;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;
    logic            in_set_flags;
    logic [3:0]      in_cond;
    logic [XLEN-1:0] alu_lhs;
    logic [XLEN-1:0] alu_rhs;
    logic [4:0]      alu_uop;
    logic [XLEN-1:0] alu_out;
    logic [3:0]      alu_flags;
    logic [3:0]      flags;
    logic            wb_valid;
    logic [3:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [3:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;
    modport slave (
        input  in_valid, in_uop, in_rd, in_rn, in_rm, in_imm, in_use_imm, in_set_flags, in_cond,
        input  alu_out, alu_flags, dbg_addr,
        output in_ready, alu_lhs, alu_rhs, alu_uop, flags, wb_valid, wb_rd, wb_data, dbg_data
    );
    modport master (
        output in_valid, in_uop, in_rd, in_rn, in_rm, in_imm, in_use_imm, in_set_flags, in_cond,
        output alu_out, alu_flags, dbg_addr,
        input  in_ready, alu_lhs, alu_rhs, alu_uop, flags, wb_valid, wb_rd, wb_data, dbg_data
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: single-slot execute sequencer feeding an external ALU with conditional commit.
// Define FORWARDING_EN to bypass alu_out into the operands instead of stalling on a RAW hazard.
module alu_issue_stage #(
    parameter int NREGS = 16,
    parameter int XLEN  = 32
) (
    input logic        clk,
    input logic        rst,
    alu_issue_if.slave bus
);
    localparam logic [4:0] NOP = 5'd0;
    localparam logic [4:0] CMP = 5'd5;

    logic [XLEN-1:0] rf_q [NREGS];
    logic [3:0]      flags_q;
    logic [XLEN-1:0] lhs_q, lhs_d, rhs_q, rhs_d, wb_data_q;
    logic [4:0]      uop_q, uop_d;
    logic [3:0]      rd_q, rd_d, cond_q, cond_d, wb_rd_q;
    logic            sf_q, sf_d, wb_valid_q;
    logic            z, c, n, v, pass, ex_wr, ex_fl, hz_rn, hz_rm, ready, acc;
    logic [XLEN-1:0] rn_val, rm_val;

    always_comb begin
        {z, c, n, v} = flags_q;
        case (cond_q)
            4'd0:    pass = z;
            4'd1:    pass = !z;
            4'd2:    pass = c;
            4'd3:    pass = !c;
            4'd4:    pass = n;
            4'd5:    pass = !n;
            4'd6:    pass = v;
            4'd7:    pass = !v;
            4'd8:    pass = c && !z;
            4'd9:    pass = !c || z;
            4'd10:   pass = n == v;
            4'd11:   pass = n != v;
            4'd12:   pass = !z && (n == v);
            4'd13:   pass = z || (n != v);
            4'd14:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    // An empty slot carries NOP, so nothing commits from it.
    assign ex_wr = pass && (uop_q inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8});
    assign ex_fl = pass && uop_q != NOP && (uop_q == CMP || sf_q);
    assign hz_rn = ex_wr && bus.in_rn == rd_q;
    assign hz_rm = ex_wr && !bus.in_use_imm && bus.in_rm == rd_q;

`ifdef FORWARDING_EN
    assign ready  = 1'b1;
    assign rn_val = hz_rn ? bus.alu_out : rf_q[bus.in_rn];
    assign rm_val = hz_rm ? bus.alu_out : rf_q[bus.in_rm];
`else
    assign ready  = !(bus.in_valid && (hz_rn || hz_rm));
    assign rn_val = rf_q[bus.in_rn];
    assign rm_val = rf_q[bus.in_rm];
`endif

    always_comb begin
        acc    = bus.in_valid && ready;
        uop_d  = acc && bus.in_uop <= 5'd8 ? bus.in_uop : NOP;
        lhs_d  = acc ? rn_val : lhs_q;
        rhs_d  = acc ? (bus.in_use_imm ? bus.in_imm : rm_val) : rhs_q;
        rd_d   = acc ? bus.in_rd : rd_q;
        cond_d = acc ? bus.in_cond : cond_q;
        sf_d   = acc && bus.in_set_flags;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            flags_q    <= '0;
            lhs_q      <= '0;
            rhs_q      <= '0;
            uop_q      <= NOP;
            rd_q       <= '0;
            cond_q     <= '0;
            sf_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            if (ex_wr) rf_q[rd_q] <= bus.alu_out;
            if (ex_fl) flags_q <= bus.alu_flags;
            if (ex_wr) wb_rd_q <= rd_q;
            if (ex_wr) wb_data_q <= bus.alu_out;
            wb_valid_q <= ex_wr;
            lhs_q      <= lhs_d;
            rhs_q      <= rhs_d;
            uop_q      <= uop_d;
            rd_q       <= rd_d;
            cond_q     <= cond_d;
            sf_q       <= sf_d;
        end
    end

    assign bus.in_ready = ready;
    assign bus.alu_lhs  = lhs_q;
    assign bus.alu_rhs  = rhs_q;
    assign bus.alu_uop  = uop_q;
    assign bus.flags    = flags_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.dbg_data = rf_q[bus.dbg_addr];
endmodule
